// File: rtl/piece_mover.sv
// piece_mover: holds the falling piece and commits moves
// only after a 16-cycle cell-by-cell collision scan.
module piece_mover #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int SPAWN_X = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_spawn,
  input  logic              cmd_left,
  input  logic              cmd_right,
  input  logic              cmd_down,
  input  logic              cmd_rot,
  input  logic [2:0]        spawn_type,
  output logic [2:0]        cand_type,
  output logic [1:0]        cand_rot,
  input  logic [3:0][3:0]   cand_mask,
  output logic [4:0]        q_row,
  output logic [3:0]        q_col,
  input  logic              q_occ,
  output logic [2:0]        piece_type,
  output logic [1:0]        piece_rot,
  output logic signed [5:0] piece_x,
  output logic signed [5:0] piece_y,
  output logic              piece_valid,
  output logic              busy,
  output logic              done,
  output logic              accepted,
  output logic              lock,
  output logic              game_over
);

  typedef enum logic [1:0] {
    IDLE, CHECK, RESOLVE
  } state_t;

  typedef enum logic [1:0] {
    OP_SPAWN, OP_DOWN, OP_MOVE
  } op_t;

  localparam logic signed [5:0] W6 = 6'(BOARD_W);
  localparam logic signed [5:0] H6 = 6'(BOARD_H);
  localparam logic signed [5:0] SX = 6'(SPAWN_X);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [3:0]        k_q, k_d;
  logic              coll_q, coll_d;
  logic [2:0]        ctype_q, ctype_d;
  logic [1:0]        crot_q, crot_d;
  logic signed [5:0] cx_q, cx_d;
  logic signed [5:0] cy_q, cy_d;
  logic [2:0]        ptype_q, ptype_d;
  logic [1:0]        prot_q, prot_d;
  logic signed [5:0] px_q, px_d;
  logic signed [5:0] py_q, py_d;
  logic              pval_q, pval_d;

  logic [1:0]        r, c;
  logic signed [5:0] row, col;
  logic              mbit, oob, hit;
  logic [1:0]        rot_nx;
  logic              s_spawn, s_down, s_rot;
  logic              s_left, s_right;

  // Next rotation wraps at 1, 2 or 4 states by shape
  always_comb begin
    rot_nx = prot_q + 2'd1;
    unique case (ptype_q)
      3'd1:                rot_nx = 2'd0;
      3'd0, 3'd5, 3'd6:    rot_nx = {1'b0, ~prot_q[0]};
      default:             rot_nx = prot_q + 2'd1;
    endcase
  end

  // Current cell of the scan and its collision test
  always_comb begin
    r    = k_q[3:2];
    c    = k_q[1:0];
    row  = cy_q + $signed({4'b0, r});
    col  = cx_q + $signed({4'b0, c});
    mbit = cand_mask[r][2'd3 - c];
    oob  = (col < 6'sd0) || (col >= W6) ||
           (row < 6'sd0) || (row >= H6);
    hit  = mbit && (oob || q_occ);
  end

  // Command priority, non-spawn needs a live piece
  always_comb begin
    s_spawn = cmd_spawn;
    s_down  = !cmd_spawn && pval_q && cmd_down;
    s_rot   = !cmd_spawn && pval_q && !cmd_down
              && cmd_rot;
    s_left  = !cmd_spawn && pval_q && !cmd_down
              && !cmd_rot && cmd_left;
    s_right = !cmd_spawn && pval_q && !cmd_down
              && !cmd_rot && !cmd_left && cmd_right;
  end

  // Next-state logic for the scan FSM and piece state
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    coll_d  = coll_q;
    ctype_d = ctype_q;
    crot_d  = crot_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ptype_d = ptype_q;
    prot_d  = prot_q;
    px_d    = px_q;
    py_d    = py_q;
    pval_d  = pval_q;
    unique case (state_q)
      IDLE: begin
        if (s_spawn || s_down || s_rot ||
            s_left || s_right) begin
          state_d = CHECK;
          k_d     = 4'd0;
          coll_d  = 1'b0;
          op_d    = OP_MOVE;
          ctype_d = ptype_q;
          crot_d  = prot_q;
          cx_d    = px_q;
          cy_d    = py_q;
        end
        unique case (1'b1)
          s_spawn: begin
            op_d    = OP_SPAWN;
            ctype_d = (spawn_type == 3'd7) ?
                      3'd0 : spawn_type;
            crot_d  = 2'd0;
            cx_d    = SX;
            cy_d    = 6'sd0;
          end
          s_down: begin
            op_d = OP_DOWN;
            cy_d = py_q + 6'sd1;
          end
          s_rot:   crot_d = rot_nx;
          s_left:  cx_d = px_q - 6'sd1;
          s_right: cx_d = px_q + 6'sd1;
          default: ;
        endcase
      end
      CHECK: begin
        coll_d = coll_q || hit;
        k_d    = k_q + 4'd1;
        if (k_q == 4'd15) state_d = RESOLVE;
      end
      RESOLVE: begin
        state_d = IDLE;
        if (!coll_q) begin
          ptype_d = ctype_q;
          prot_d  = crot_q;
          px_d    = cx_q;
          py_d    = cy_q;
          if (op_q == OP_SPAWN) pval_d = 1'b1;
        end else if (op_q == OP_SPAWN) begin
          pval_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_SPAWN;
      k_q     <= '0;
      coll_q  <= 1'b0;
      ctype_q <= '0;
      crot_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ptype_q <= '0;
      prot_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      k_q     <= k_d;
      coll_q  <= coll_d;
      ctype_q <= ctype_d;
      crot_q  <= crot_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ptype_q <= ptype_d;
      prot_q  <= prot_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pval_q  <= pval_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    cand_type   = ctype_q;
    cand_rot    = crot_q;
    q_row       = (state_q == CHECK) ? row[4:0] : 5'd0;
    q_col       = (state_q == CHECK) ? col[3:0] : 4'd0;
    piece_type  = ptype_q;
    piece_rot   = prot_q;
    piece_x     = px_q;
    piece_y     = py_q;
    piece_valid = pval_q;
    busy        = (state_q != IDLE);
    done        = (state_q == RESOLVE);
    accepted    = done && !coll_q;
    lock        = done && coll_q && (op_q == OP_DOWN);
    game_over   = done && coll_q && (op_q == OP_SPAWN);
  end

endmodule

// File: tb/tb_piece_mover.sv
// tb_piece_mover: directed checks of piece_mover with a
// bench-side sprite table and board occupancy array.
module tb_piece_mover;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              cmd_spawn, cmd_left, cmd_right;
  logic              cmd_down, cmd_rot;
  logic [2:0]        spawn_type;
  logic [2:0]        cand_type;
  logic [1:0]        cand_rot;
  logic [3:0][3:0]   cand_mask;
  logic [4:0]        q_row;
  logic [3:0]        q_col;
  logic              q_occ;
  logic [2:0]        piece_type;
  logic [1:0]        piece_rot;
  logic signed [5:0] piece_x, piece_y;
  logic              piece_valid, busy, done;
  logic              accepted, lock, game_over;

  logic occ [0:19][0:9];

  int n_tests = 0;
  int n_fail  = 0;
  int done_at, done_n, acc, busy_n, lock_n, go_n;

  localparam logic [4:0] C_SPAWN = 5'b10000;
  localparam logic [4:0] C_DOWN  = 5'b01000;
  localparam logic [4:0] C_ROT   = 5'b00100;
  localparam logic [4:0] C_LEFT  = 5'b00010;
  localparam logic [4:0] C_RIGHT = 5'b00001;

  always #5 Clk = ~Clk;

  piece_mover dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_spawn(cmd_spawn), .cmd_left(cmd_left),
    .cmd_right(cmd_right), .cmd_down(cmd_down),
    .cmd_rot(cmd_rot), .spawn_type(spawn_type),
    .cand_type(cand_type), .cand_rot(cand_rot),
    .cand_mask(cand_mask), .q_row(q_row),
    .q_col(q_col), .q_occ(q_occ),
    .piece_type(piece_type), .piece_rot(piece_rot),
    .piece_x(piece_x), .piece_y(piece_y),
    .piece_valid(piece_valid), .busy(busy),
    .done(done), .accepted(accepted),
    .lock(lock), .game_over(game_over)
  );

  function automatic logic [3:0][3:0] sprite(
    input logic [2:0] t, input logic [1:0] r);
    logic [3:0][3:0] m;
    m = '0;
    case (t)
      3'd0, 3'd7: begin
        if (r[0]) begin
          m[0] = 4'b0010; m[1] = 4'b0010;
          m[2] = 4'b0010; m[3] = 4'b0010;
        end else begin
          m[0] = 4'b1111;
        end
      end
      3'd1: begin
        m[0] = 4'b0110; m[1] = 4'b0110;
      end
      3'd6: begin
        if (r[0]) begin
          m[0] = 4'b0010; m[1] = 4'b0110;
          m[2] = 4'b0100;
        end else begin
          m[0] = 4'b1100; m[1] = 4'b0110;
        end
      end
      default: begin
        m[0] = 4'b0100; m[1] = 4'b1110;
      end
    endcase
    return m;
  endfunction

  always_comb cand_mask = sprite(cand_type, cand_rot);

  always_comb begin
    q_occ = 1'b0;
    if (q_row < 5'd20 && q_col < 4'd10)
      q_occ = occ[int'(q_row)][int'(q_col)];
  end

  task automatic check(input string tag,
                       input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 10; j++)
        occ[i][j] = 1'b0;
  endtask

  task automatic set_cmd(input logic [4:0] c);
    {cmd_spawn, cmd_down, cmd_rot, cmd_left, cmd_right} = c;
  endtask

  task automatic observe(input int ncyc);
    done_at = 0; done_n = 0; acc = 0;
    busy_n = 0; lock_n = 0; go_n = 0;
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) @(negedge Clk);
      if (busy) busy_n++;
      if (lock) lock_n++;
      if (game_over) go_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = n;
          acc = int'(accepted);
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [4:0] c,
                         input logic [2:0] st);
    @(negedge Clk);
    set_cmd(c);
    spawn_type = st;
    @(negedge Clk);
    set_cmd(5'b0);
    observe(24);
  endtask

  initial begin
    clear_board();
    set_cmd(5'b0);
    spawn_type = 3'd0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("reset_outs",
          int'({piece_type, piece_rot, piece_x, piece_y,
                piece_valid, busy, done, accepted, lock,
                game_over, cand_type, cand_rot, q_row,
                q_col}), 0);

    // reset in cycle 5 of a spawn check
    @(negedge Clk);
    set_cmd(C_SPAWN);
    spawn_type = 3'd3;
    @(negedge Clk);
    set_cmd(5'b0);
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_outs",
          int'({piece_type, piece_rot, piece_x, piece_y,
                piece_valid, busy, done, cand_type,
                cand_rot}), 0);
    observe(24);
    check("midrst_no_done", done_n, 0);

    // spawn T on empty board
    run_cmd(C_SPAWN, 3'd3);
    check("spawnT_done_at", done_at, 17);
    check("spawnT_acc", acc, 1);
    check("spawnT_busy_n", busy_n, 17);
    check("spawnT_done_n", done_n, 1);
    check("spawnT_x", int'(piece_x), 3);
    check("spawnT_y", int'(piece_y), 0);
    check("spawnT_rot", int'(piece_rot), 0);
    check("spawnT_type", int'(piece_type), 3);
    check("spawnT_valid", int'(piece_valid), 1);

    // down into occupied (1,4)
    occ[1][4] = 1'b1;
    run_cmd(C_DOWN, 3'd0);
    check("downT_acc", acc, 0);
    check("downT_lock", lock_n, 1);
    check("downT_y", int'(piece_y), 0);

    // spawn T onto occupied (1,4)
    run_cmd(C_SPAWN, 3'd3);
    check("go_acc", acc, 0);
    check("go_pulse", go_n, 1);
    check("go_valid", int'(piece_valid), 0);
    check("go_type", int'(piece_type), 3);

    // moves ignored with no piece
    run_cmd(C_LEFT | C_DOWN, 3'd0);
    check("novalid_done", done_n, 0);
    check("novalid_busy", busy_n, 0);

    // I piece against left wall
    clear_board();
    run_cmd(C_SPAWN, 3'd0);
    check("spawnI_acc", acc, 1);
    repeat (3) run_cmd(C_LEFT, 3'd0);
    check("I_left_x0", int'(piece_x), 0);
    run_cmd(C_LEFT, 3'd0);
    check("I_wall_acc", acc, 0);
    check("I_wall_x", int'(piece_x), 0);
    check("I_wall_lock", lock_n, 0);

    // I piece against right wall
    repeat (6) run_cmd(C_RIGHT, 3'd0);
    check("I_right_x6", int'(piece_x), 6);
    run_cmd(C_RIGHT, 3'd0);
    check("I_rwall_acc", acc, 0);
    check("I_rwall_x", int'(piece_x), 6);

    // down beats left; then fall to the floor
    run_cmd(C_DOWN | C_LEFT | C_ROT, 3'd0);
    check("prio_y", int'(piece_y), 1);
    check("prio_x", int'(piece_x), 6);
    check("prio_rot", int'(piece_rot), 0);
    repeat (18) run_cmd(C_DOWN, 3'd0);
    check("I_y19", int'(piece_y), 19);
    run_cmd(C_DOWN, 3'd0);
    check("floor_acc", acc, 0);
    check("floor_lock", lock_n, 1);
    check("floor_y", int'(piece_y), 19);

    // O rotation stays at 0
    run_cmd(C_SPAWN, 3'd1);
    run_cmd(C_ROT, 3'd0);
    check("O_rot_acc", acc, 1);
    check("O_rot", int'(piece_rot), 0);

    // Z rotation wraps after 2
    run_cmd(C_SPAWN, 3'd6);
    run_cmd(C_ROT, 3'd0);
    check("Z_rot1", int'(piece_rot), 1);
    run_cmd(C_ROT, 3'd0);
    check("Z_rot0_acc", acc, 1);
    check("Z_rot0", int'(piece_rot), 0);

    // type 7 spawns as I
    run_cmd(C_SPAWN, 3'd7);
    check("t7_type", int'(piece_type), 0);
    check("t7_valid", int'(piece_valid), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_mover.md
Name: piece_mover

Overview:
- Holds the falling Tetris piece: type, rotation, x and y board position.
- Applies spawn, left, right, down and rotate commands only after a collision check of the candidate placement.
- The check scans the candidate's 4x4 sprite mask cell by cell against the board occupancy store.
- Sits between the input/gravity controller (upstream, issues commands) and the board/locking logic (downstream, consumes piece state and the lock pulse). The sprite table is addressed through cand_type/cand_rot.

Parameters:
- BOARD_W, 10, board columns.
- BOARD_H, 20, board rows.
- SPAWN_X, 3, column of the mask's left edge at spawn.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- cmd_spawn  in  1  spawn request.
- cmd_left  in  1  move-left request.
- cmd_right  in  1  move-right request.
- cmd_down  in  1  move-down request.
- cmd_rot  in  1  rotate request.
- spawn_type  in  3  piece type to spawn: 0 I, 1 O, 2 J, 3 T, 4 L, 5 S, 6 Z; 7 is treated as 0.
- cand_type  out  3  type of the piece being checked, used to select the sprite.
- cand_rot  out  2  rotation of the piece being checked.
- cand_mask  in  4x[3:0]  sprite rows for cand_type/cand_rot; row 0 is the top; bit 3 is the leftmost column.
- q_row  out  5  board row being queried.
- q_col  out  4  board column being queried.
- q_occ  in  1  occupancy of (q_row, q_col); combinational, valid in the same cycle.
- piece_type  out  3  committed piece type.
- piece_rot  out  2  committed rotation.
- piece_x  out  6  committed column of the mask's left edge, signed.
- piece_y  out  6  committed row of the mask's top edge, signed.
- piece_valid  out  1  a piece is active.
- busy  out  1  high while a check is in progress.
- done  out  1  1-cycle pulse when a check ends.
- accepted  out  1  valid when done is high: 1 = candidate committed.
- lock  out  1  1-cycle pulse: a down command was rejected.
- game_over  out  1  1-cycle pulse: a spawn was rejected.

Behaviour:
- Reset (synchronous, active-high, Clk): state IDLE.
  - All outputs 0, including piece_* and cand_*.
  - Reset while in CHECK aborts the check: no done pulse, committed state cleared.
- IDLE:
  - Commands are sampled only in IDLE.
  - Priority when several are high: spawn > down > rot > left > right.
  - Non-spawn commands are ignored while piece_valid=0, with no done pulse.
  - Commands arriving while busy are dropped, not queued.
- Candidate registered on command acceptance:
  - spawn: type=spawn_type, rot=0, x=SPAWN_X, y=0.
  - left: x-1.
  - right: x+1.
  - down: y+1.
  - rot: rot+1 modulo N, where N=1 for O; N=2 for I, S, Z; N=4 for J, T, L. A rotation with N=1 still runs a check.
  - cand_type/cand_rot hold constant through CHECK; cand_mask is treated as stable.
- CHECK:
  - Runs exactly 16 cycles; cell index k=0..15, r=k/4, c=k%4.
  - Per cycle: row = cand_y + r, col = cand_x + c (signed 6-bit). q_row and q_col are driven with those values truncated to port width.
  - A cell collides if its mask bit cand_mask[r][3-c] is 1 and any of the following holds:
    - col < 0 or col >= BOARD_W;
    - row < 0 or row >= BOARD_H;
    - q_occ = 1.
  - q_occ is ignored for mask-0 cells and for out-of-bounds cells.
  - The collision flag is sticky for the whole check.
- RESOLVE (1 cycle after CHECK):
  - done=1 and accepted=!collision.
  - If accepted: piece_* take the candidate values. On spawn, piece_valid=1.
  - If rejected: piece_* unchanged.
    - A rejected down also pulses lock.
    - A rejected spawn pulses game_over, clears piece_valid and leaves piece_type/rot/x/y unchanged.
  - Returns to IDLE.
- Latency and busy:
  - Command sampled in cycle 0, done in cycle 17.
  - busy is high in cycles 1..17.
  - The next command can be accepted in cycle 18.
- Spawn while a piece is active simply replaces it after a successful check.

Test Plan:
- Reset mid-check: spawn T, then assert Reset in cycle 5 -> no done pulse; all outputs 0; next spawn completes normally at +17 cycles.
- Spawn T (3) on an empty board -> done with accepted=1 at cycle 17; piece_x=3, piece_y=0, piece_rot=0, piece_valid=1; busy high for exactly 17 cycles.
- I at x=0, then cmd_left -> accepted=0, x stays 0, no lock pulse. Also: I at x=6 horizontal (rot 0), cmd_right -> x=7 places a mask cell at col 10, so accepted=0.
- O piece, cmd_rot -> accepted=1, rot stays 0. Z at rot 1, cmd_rot -> rot becomes 0.
- I horizontal at y=19, cmd_down -> accepted=0, lock pulses for 1 cycle, y stays 19. With board cell (row 1, col 4) occupied, cmd_down on T at y=0, x=3 -> rejected and lock pulses.
- Board cell (row 1, col 4) occupied, spawn T -> game_over pulses and piece_valid=0. Then assert cmd_left and cmd_down together with piece_valid=0 -> both ignored, no done pulse.
